// File: rtl/execute_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : execute_unit_if
//  Description : Issue (ID/EX), forwarding and result (EX/MEM) signal bundle
//                of the execute stage. The pipeline side uses the master
//                modport, the execute unit uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface execute_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  // Issue side
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic              alu_src;
  logic              reg_write;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   data1;
  logic [XLEN-1:0]   data2;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  // Forwarding sources
  logic [REG_AW-1:0] ex_mem_rd;
  logic [REG_AW-1:0] mem_wb_rd;
  logic              ex_mem_reg_write;
  logic              mem_wb_reg_write;
  logic [XLEN-1:0]   fwd_ex_mem;
  logic [XLEN-1:0]   fwd_mem_wb;
  // Result side
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   store_data;
  logic [XLEN-1:0]   branch_target;
  logic [REG_AW-1:0] rd_out;
  logic              reg_write_out;
  logic              branch_taken;
  logic              busy;

  modport master (
    output flush, in_valid, op, is_branch, is_jal, is_jalr, alu_src, reg_write,
           funct3, pc, data1, data2, imm, rs1, rs2, rd,
           ex_mem_rd, mem_wb_rd, ex_mem_reg_write, mem_wb_reg_write,
           fwd_ex_mem, fwd_mem_wb, out_ready,
    input  in_ready, out_valid, alu_result, store_data, branch_target,
           rd_out, reg_write_out, branch_taken, busy
  );

  modport slave (
    input  flush, in_valid, op, is_branch, is_jal, is_jalr, alu_src, reg_write,
           funct3, pc, data1, data2, imm, rs1, rs2, rd,
           ex_mem_rd, mem_wb_rd, ex_mem_reg_write, mem_wb_reg_write,
           fwd_ex_mem, fwd_mem_wb, out_ready,
    output in_ready, out_valid, alu_result, store_data, branch_target,
           rd_out, reg_write_out, branch_taken, busy
  );
endinterface
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : execute_unit
//  Description : RV32/RV64 execute stage. Operand forwarding, single-cycle
//                ALU/multiply, branch/jump resolution, iterative restoring
//                divider, registered EX/MEM output with valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DIV_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  execute_unit_if.slave   ex_if
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  // Operand values
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  logic [XLEN-1:0]   w_op_b;
  logic [SHW-1:0]    w_shamt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_alu;
  logic              w_br_cond;

  // Single-cycle result
  logic [XLEN-1:0]   w_sc_res;
  logic [XLEN-1:0]   w_sc_tgt;
  logic              w_sc_taken;
  logic              w_sc_rw;

  // Handshake
  logic              w_out_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_div;
  logic              w_sc_load;
  logic              w_fin_load;

  // Divider
  logic              w_div_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic              w_div_last;
  logic [XLEN-1:0]   w_div_quo;
  logic [XLEN-1:0]   w_div_rem;
  logic [XLEN-1:0]   w_div_res;

  logic [SHW-1:0]    div_cnt_q;
  logic [XLEN-1:0]   div_quo_q;
  logic [XLEN-1:0]   div_rem_q;
  logic [XLEN-1:0]   div_dvs_q;
  logic              div_negq_q;
  logic              div_negr_q;
  logic              div_isrem_q;
  logic [REG_AW-1:0] div_rd_q;
  logic              div_rw_q;
  logic [XLEN-1:0]   div_sd_q;

  // Output register
  logic              out_valid_q;
  logic [XLEN-1:0]   alu_res_q;
  logic [XLEN-1:0]   store_data_q;
  logic [XLEN-1:0]   target_q;
  logic [REG_AW-1:0] rd_out_q;
  logic              rw_out_q;
  logic              taken_q;

  // Forward each source operand; EX/MEM wins over MEM/WB, x0 never forwarded
  always_comb begin
    w_rs1_val = ex_if.data1;
    w_rs2_val = ex_if.data2;
    if (ex_if.rs1 != '0 && ex_if.ex_mem_reg_write && ex_if.ex_mem_rd == ex_if.rs1)
      w_rs1_val = ex_if.fwd_ex_mem;
    else if (ex_if.rs1 != '0 && ex_if.mem_wb_reg_write && ex_if.mem_wb_rd == ex_if.rs1)
      w_rs1_val = ex_if.fwd_mem_wb;
    if (ex_if.rs2 != '0 && ex_if.ex_mem_reg_write && ex_if.ex_mem_rd == ex_if.rs2)
      w_rs2_val = ex_if.fwd_ex_mem;
    else if (ex_if.rs2 != '0 && ex_if.mem_wb_reg_write && ex_if.mem_wb_rd == ex_if.rs2)
      w_rs2_val = ex_if.fwd_mem_wb;
  end

  assign w_op_b  = ex_if.alu_src ? ex_if.imm : w_rs2_val;
  assign w_shamt = w_op_b[SHW-1:0];
  // Sign-extended full-width product; low half serves MUL, high half MULH
  assign w_prod  = $signed({{XLEN{w_rs1_val[XLEN-1]}}, w_rs1_val}) *
                   $signed({{XLEN{w_op_b[XLEN-1]}}, w_op_b});

  // Single-cycle ALU and multiplier; divide opcodes give 0 when not routed to the divider
  always_comb begin
    w_alu = '0;
    case (ex_if.op)
      OP_ADD:  w_alu = w_rs1_val + w_op_b;
      OP_SUB:  w_alu = w_rs1_val - w_op_b;
      OP_AND:  w_alu = w_rs1_val & w_op_b;
      OP_OR:   w_alu = w_rs1_val | w_op_b;
      OP_XOR:  w_alu = w_rs1_val ^ w_op_b;
      OP_SLL:  w_alu = w_rs1_val << w_shamt;
      OP_SRL:  w_alu = w_rs1_val >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(w_rs1_val) >>> w_shamt);
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_rs1_val) < $signed(w_op_b))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_rs1_val < w_op_b)};
      OP_MUL:  w_alu = w_prod[XLEN-1:0];
      OP_MULH: w_alu = w_prod[2*XLEN-1:XLEN];
      default: w_alu = '0;
    endcase
  end

  // Branch condition on forwarded rs1/rs2
  always_comb begin
    w_br_cond = 1'b0;
    case (ex_if.funct3)
      3'b000:  w_br_cond = (w_rs1_val == w_rs2_val);
      3'b001:  w_br_cond = (w_rs1_val != w_rs2_val);
      3'b100:  w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101:  w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_br_cond = (w_rs1_val <  w_rs2_val);
      3'b111:  w_br_cond = (w_rs1_val >= w_rs2_val);
      default: w_br_cond = 1'b0;
    endcase
  end

  // Merge jump/branch semantics over the plain ALU result
  always_comb begin
    w_sc_res   = w_alu;
    w_sc_tgt   = ex_if.pc + ex_if.imm;
    w_sc_taken = 1'b0;
    w_sc_rw    = ex_if.reg_write;
    if (ex_if.is_jal) begin
      w_sc_res   = ex_if.pc + XLEN'(4);
      w_sc_taken = 1'b1;
    end else if (ex_if.is_jalr) begin
      w_sc_res   = ex_if.pc + XLEN'(4);
      w_sc_tgt   = (w_rs1_val + ex_if.imm) & ~XLEN'(1);
      w_sc_taken = 1'b1;
    end else if (ex_if.is_branch) begin
      w_sc_res   = '0;
      w_sc_rw    = 1'b0;
      w_sc_taken = w_br_cond;
    end
  end

  assign w_is_div   = (DIV_EN != 0) && (ex_if.op[3:2] == 2'b11) &&
                      !ex_if.is_branch && !ex_if.is_jal && !ex_if.is_jalr;
  assign w_out_free = !out_valid_q || ex_if.out_ready;
  assign w_in_ready = (state_q == ST_IDLE) && w_out_free && !ex_if.flush;
  assign w_accept   = ex_if.in_valid && w_in_ready;
  assign w_sc_load  = w_accept && !w_is_div;
  assign w_fin_load = (state_q == ST_FIN) && w_out_free && !ex_if.flush;

  // Divide operand preparation: op[0]=0 selects signed, op[1]=1 selects remainder
  assign w_div_signed = !ex_if.op[0];
  assign w_a_neg      = w_div_signed && w_rs1_val[XLEN-1];
  assign w_b_neg      = w_div_signed && w_op_b[XLEN-1];
  assign w_a_mag      = w_a_neg ? (~w_rs1_val + XLEN'(1)) : w_rs1_val;
  assign w_b_mag      = w_b_neg ? (~w_op_b + XLEN'(1)) : w_op_b;

  // One restoring step: dividend bits shift out of the quotient register as quotient bits shift in
  assign w_rem_sh   = {div_rem_q, div_quo_q[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, div_dvs_q};
  assign w_qbit     = !w_diff[XLEN];
  assign w_div_last = (div_cnt_q == SHW'(XLEN - 1));

  // Sign fix-up; a zero divisor leaves all-ones quotient and the dividend as remainder
  assign w_div_quo = div_negq_q ? (~div_quo_q + XLEN'(1)) : div_quo_q;
  assign w_div_rem = div_negr_q ? (~div_rem_q + XLEN'(1)) : div_rem_q;
  assign w_div_res = div_isrem_q ? w_div_rem : w_div_quo;

  // Divider FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Divider FSM next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept && w_is_div) state_d = ST_DIV;
      ST_DIV:  if (w_div_last)           state_d = ST_FIN;
      ST_FIN:  if (w_out_free)           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
    if (ex_if.flush) state_d = ST_IDLE;
  end

  // Divider datapath: latch magnitudes on accept, iterate while dividing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      div_quo_q   <= '0;
      div_rem_q   <= '0;
      div_dvs_q   <= '0;
      div_negq_q  <= 1'b0;
      div_negr_q  <= 1'b0;
      div_isrem_q <= 1'b0;
      div_rd_q    <= '0;
      div_rw_q    <= 1'b0;
      div_sd_q    <= '0;
    end else if (w_accept && w_is_div) begin
      div_cnt_q   <= '0;
      div_quo_q   <= w_a_mag;
      div_rem_q   <= '0;
      div_dvs_q   <= w_b_mag;
      div_negq_q  <= (w_a_neg ^ w_b_neg) && (w_op_b != '0);
      div_negr_q  <= w_a_neg;
      div_isrem_q <= ex_if.op[1];
      div_rd_q    <= ex_if.rd;
      div_rw_q    <= ex_if.reg_write;
      div_sd_q    <= w_rs2_val;
    end else if (state_q == ST_DIV) begin
      div_cnt_q <= div_cnt_q + SHW'(1);
      div_quo_q <= {div_quo_q[XLEN-2:0], w_qbit};
      div_rem_q <= w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    end
  end

  // EX/MEM output register: flush kills, else load single-cycle or divide result, else drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_res_q    <= '0;
      store_data_q <= '0;
      target_q     <= '0;
      rd_out_q     <= '0;
      rw_out_q     <= 1'b0;
      taken_q      <= 1'b0;
    end else if (ex_if.flush) begin
      out_valid_q  <= 1'b0;
    end else if (w_sc_load) begin
      out_valid_q  <= 1'b1;
      alu_res_q    <= w_sc_res;
      store_data_q <= w_rs2_val;
      target_q     <= w_sc_tgt;
      rd_out_q     <= ex_if.rd;
      rw_out_q     <= w_sc_rw;
      taken_q      <= w_sc_taken;
    end else if (w_fin_load) begin
      out_valid_q  <= 1'b1;
      alu_res_q    <= w_div_res;
      store_data_q <= div_sd_q;
      target_q     <= '0;
      rd_out_q     <= div_rd_q;
      rw_out_q     <= div_rw_q;
      taken_q      <= 1'b0;
    end else if (ex_if.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign ex_if.in_ready      = w_in_ready;
  assign ex_if.out_valid     = out_valid_q;
  assign ex_if.alu_result    = alu_res_q;
  assign ex_if.store_data    = store_data_q;
  assign ex_if.branch_target = target_q;
  assign ex_if.rd_out        = rd_out_q;
  assign ex_if.reg_write_out = rw_out_q;
  assign ex_if.branch_taken  = taken_q && out_valid_q;
  assign ex_if.busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_unit
//  Description : Self-checking bench for execute_unit (XLEN=32) with a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_unit;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  execute_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  execute_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .DIV_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        isb, jal, jalr, alusrc, rw;
    logic [2:0]  f3;
    logic [31:0] pc, d1, d2, imm, fex, fwb;
    logic [4:0]  rs1, rs2, rd, exrd, wbrd;
    logic        exw, wbw;
  } stim_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] tgt;
    logic        taken;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;

  function automatic stim_t blank();
    stim_t s;
    s.op = 0; s.isb = 0; s.jal = 0; s.jalr = 0; s.alusrc = 0; s.rw = 1; s.f3 = 0;
    s.pc = 32'h100; s.d1 = 0; s.d2 = 0; s.imm = 0; s.fex = 0; s.fwb = 0;
    s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.exrd = 0; s.wbrd = 0; s.exw = 0; s.wbw = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim(input int lo, input int hi);
    stim_t s = blank();
    s.op     = 4'($urandom_range(hi, lo));
    s.d1     = ($urandom_range(0, 3) == 0) ? 32'(-$urandom_range(0, 50)) : $urandom;
    s.d2     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    s.imm    = $urandom;
    s.pc     = $urandom & 32'hFFFF_FFFC;
    s.rs1    = 5'($urandom_range(0, 3));
    s.rs2    = 5'($urandom_range(0, 3));
    s.rd     = 5'($urandom_range(0, 31));
    s.exrd   = 5'($urandom_range(0, 3));
    s.wbrd   = 5'($urandom_range(0, 3));
    s.exw    = 1'($urandom_range(0, 1));
    s.wbw    = 1'($urandom_range(0, 1));
    s.fex    = $urandom;
    s.fwb    = $urandom;
    s.alusrc = 1'($urandom_range(0, 1));
    s.rw     = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] d, input stim_t s);
    if (rs != 0 && s.exw && s.exrd == rs) return s.fex;
    if (rs != 0 && s.wbw && s.wbrd == rs) return s.fwb;
    return d;
  endfunction

  // Reference behaviour from the instruction semantics
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] a, b2, b;
    int sa, sb, sb2;
    longint p;
    a = fwd_val(s.rs1, s.d1, s);
    b2 = fwd_val(s.rs2, s.d2, s);
    b = s.alusrc ? s.imm : b2;
    sa = a; sb = b; sb2 = b2;
    e.sd = b2; e.rd = s.rd; e.rw = s.rw; e.taken = 0; e.tgt = s.pc + s.imm; e.alu = 0;
    if (s.jal) begin
      e.alu = s.pc + 4; e.taken = 1;
    end else if (s.jalr) begin
      e.alu = s.pc + 4; e.taken = 1; e.tgt = (a + s.imm) & 32'hFFFF_FFFE;
    end else if (s.isb) begin
      e.rw = 0;
      case (s.f3)
        3'd0: e.taken = (a == b2);
        3'd1: e.taken = (a != b2);
        3'd4: e.taken = (sa < sb2);
        3'd5: e.taken = (sa >= sb2);
        3'd6: e.taken = (a < b2);
        3'd7: e.taken = (a >= b2);
        default: e.taken = 0;
      endcase
    end else begin
      case (s.op)
        4'd0:  e.alu = a + b;
        4'd1:  e.alu = a - b;
        4'd2:  e.alu = a & b;
        4'd3:  e.alu = a | b;
        4'd4:  e.alu = a ^ b;
        4'd5:  e.alu = a << b[4:0];
        4'd6:  e.alu = a >> b[4:0];
        4'd7:  e.alu = sa >>> b[4:0];
        4'd8:  e.alu = (sa < sb) ? 1 : 0;
        4'd9:  e.alu = (a < b) ? 1 : 0;
        4'd10: begin p = longint'(sa) * longint'(sb); e.alu = p[31:0]; end
        4'd11: begin p = longint'(sa) * longint'(sb); e.alu = p[63:32]; end
        4'd12: e.alu = (b == 0) ? 32'hFFFF_FFFF :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
        4'd13: e.alu = (b == 0) ? 32'hFFFF_FFFF : a / b;
        4'd14: e.alu = (b == 0) ? a :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
        default: e.alu = (b == 0) ? a : a % b;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t e;
    e.alu = bus.alu_result; e.sd = bus.store_data; e.tgt = bus.branch_target;
    e.taken = bus.branch_taken; e.rw = bus.reg_write_out; e.rd = bus.rd_out;
    return e;
  endfunction

  // Fields compared for non-control ops (target is only meaningful for branches/jumps)
  function automatic logic [70:0] core(input exp_t e);
    return {e.alu, e.sd, e.taken, e.rw, e.rd};
  endfunction

  task automatic apply(input stim_t s);
    bus.op = s.op; bus.is_branch = s.isb; bus.is_jal = s.jal; bus.is_jalr = s.jalr;
    bus.alu_src = s.alusrc; bus.reg_write = s.rw; bus.funct3 = s.f3; bus.pc = s.pc;
    bus.data1 = s.d1; bus.data2 = s.d2; bus.imm = s.imm; bus.rs1 = s.rs1; bus.rs2 = s.rs2;
    bus.rd = s.rd; bus.ex_mem_rd = s.exrd; bus.mem_wb_rd = s.wbrd;
    bus.ex_mem_reg_write = s.exw; bus.mem_wb_reg_write = s.wbw;
    bus.fwd_ex_mem = s.fex; bus.fwd_mem_wb = s.fwb;
  endtask

  // Issue one op and wait (bounded) for its result; ok=0 if the bound expires
  task automatic run_op(input stim_t s, output exp_t obs, output bit ok);
    int g;
    apply(s);
    bus.in_valid = 1'b1;
    #1;
    g = 0;
    while (!bus.in_ready && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 200) begin @(posedge clk); #1; g++; end
    obs = observe();
    ok  = bus.out_valid;
  endtask

  task automatic test_reset();
    logic [103:0] got;
    rst_n = 1'b0;
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    apply(blank());
    repeat (3) @(posedge clk);
    #1;
    got = {bus.out_valid, bus.alu_result, bus.store_data, bus.branch_target,
           bus.rd_out, bus.reg_write_out, bus.branch_taken, bus.busy};
    total_cnt++;
    if (got !== '0) $display("FAIL reset_outputs got=%h want=0", got);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    stim_t s; exp_t o; bit ok;
    s = blank();
    s.rs1 = 5; s.exrd = 5; s.wbrd = 5; s.exw = 1; s.wbw = 1; s.fex = 7; s.fwb = 9;
    s.rs2 = 6; s.d2 = 3; s.d1 = 32'h55;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.alu !== 32'd10) $display("FAIL fwd_ex_mem_priority got=%h ok=%b want=a", o.alu, ok);
    else pass_cnt++;
    s.rs1 = 0; s.d1 = 32'h20;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.alu !== 32'h23) $display("FAIL fwd_x0 got=%h want=23", o.alu);
    else pass_cnt++;
    s.rs1 = 5; s.exw = 0;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.alu !== 32'd12) $display("FAIL fwd_mem_wb got=%h want=c", o.alu);
    else pass_cnt++;
    s.rs2 = 5; s.exw = 1; s.alusrc = 1; s.imm = 32'h100;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.alu !== 32'h107 || o.sd !== 32'd7)
      $display("FAIL fwd_store_data got alu=%h sd=%h want alu=107 sd=7", o.alu, o.sd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    stim_t s; exp_t e, o;
    bus.out_ready = 1;
    for (int i = 0; i < 60; i++) begin
      s = rand_stim(0, 11);
      apply(s);
      bus.in_valid = 1'b1;
      #1;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got=%b want=1", i, bus.in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      e = model(s); o = observe();
      total_cnt++;
      if (bus.out_valid !== 1'b1 || core(o) !== core(e))
        $display("FAIL b2b_result[%0d] op=%0d got v=%b alu=%h sd=%h rw=%b rd=%0d want alu=%h sd=%h rw=%b rd=%0d",
                 i, s.op, bus.out_valid, o.alu, o.sd, o.rw, o.rd, e.alu, e.sd, e.rw, e.rd);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got=%b want=0", bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_branches();
    stim_t s; exp_t e, o; bit ok;
    s = blank(); s.isb = 1; s.f3 = 3'd4; s.d1 = 32'hFFFF_FFFF; s.d2 = 1; s.imm = 32'h40;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.taken !== 1'b1 || o.tgt !== 32'h140 || o.alu !== 0 || o.rw !== 0)
      $display("FAIL blt_taken got t=%b tgt=%h alu=%h rw=%b want t=1 tgt=140 alu=0 rw=0", o.taken, o.tgt, o.alu, o.rw);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.branch_taken !== 1'b0) $display("FAIL taken_qualified got=%b want=0", bus.branch_taken);
    else pass_cnt++;
    s.f3 = 3'd6;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.taken !== 1'b0) $display("FAIL bltu_not_taken got=%b want=0", o.taken);
    else pass_cnt++;
    s = blank(); s.jalr = 1; s.d1 = 32'h1001; s.imm = 2; s.pc = 32'h200;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.tgt !== 32'h1002 || o.alu !== 32'h204 || o.taken !== 1'b1)
      $display("FAIL jalr got tgt=%h alu=%h t=%b want tgt=1002 alu=204 t=1", o.tgt, o.alu, o.taken);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      s = rand_stim(0, 0);
      s.isb = (i % 3 == 0); s.jal = (i % 3 == 1); s.jalr = (i % 3 == 2);
      s.f3 = 3'($urandom_range(0, 7));
      if (i % 2 == 0) s.d2 = s.d1;
      run_op(s, o, ok);
      e = model(s);
      total_cnt++;
      if (!ok || o !== e)
        $display("FAIL ctrl_rand[%0d] got alu=%h tgt=%h t=%b rw=%b want alu=%h tgt=%h t=%b rw=%b",
                 i, o.alu, o.tgt, o.taken, o.rw, e.alu, e.tgt, e.taken, e.rw);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_latency();
    stim_t s; exp_t o; bit ok; int cycles, bad;
    s = blank(); s.op = 4'd13; s.d1 = 100; s.d2 = 7;
    @(posedge clk); #1;
    apply(s);
    bus.in_valid = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL divu_accept got=%b want=1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cycles = 0; bad = 0;
    while (!bus.out_valid && cycles < 100) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      cycles++;
    end
    total_cnt++;
    if (cycles != 33) $display("FAIL divu_latency got=%0d want=33", cycles);
    else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL divu_busy_stall got=%0d bad cycles want=0", bad);
    else pass_cnt++;
    total_cnt++;
    if (bus.alu_result !== 32'd14 || bus.busy !== 1'b0)
      $display("FAIL divu_result got=%h busy=%b want=e busy=0", bus.alu_result, bus.busy);
    else pass_cnt++;
    s.op = 4'd15;
    run_op(s, o, ok);
    total_cnt++;
    if (!ok || o.alu !== 32'd2) $display("FAIL remu_result got=%h want=2", o.alu);
    else pass_cnt++;
  endtask

  task automatic test_div_edges();
    stim_t s; exp_t e, o; bit ok;
    logic [3:0]  ops [4] = '{4'd12, 4'd14, 4'd12, 4'd14};
    logic [31:0] da  [4] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] db  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] want[4] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 4; i++) begin
      s = blank(); s.op = ops[i]; s.d1 = da[i]; s.d2 = db[i];
      run_op(s, o, ok);
      total_cnt++;
      if (!ok || o.alu !== want[i]) $display("FAIL div_edge[%0d] got=%h want=%h", i, o.alu, want[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      s = rand_stim(12, 15);
      if (i == 0) begin s.d2 = 0; s.alusrc = 0; s.rs2 = 0; s.d1 = 32'hFFFF_FFF9; s.rs1 = 0; end
      run_op(s, o, ok);
      e = model(s);
      total_cnt++;
      if (!ok || core(o) !== core(e))
        $display("FAIL div_rand[%0d] op=%0d got=%h sd=%h want=%h sd=%h", i, s.op, o.alu, o.sd, e.alu, e.sd);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    stim_t s;
    @(posedge clk); #1;
    bus.out_ready = 0;
    s = blank(); s.d1 = 5; s.d2 = 6; s.rd = 9;
    apply(s);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    s = blank(); s.op = 4'd11; s.d1 = 32'hFFFF_FFFF; s.d2 = 32'hFFFF_FFFF; s.rd = 10;
    apply(s);
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd11 || bus.rd_out !== 5'd9)
      $display("FAIL bp_hold got v=%b alu=%h rd=%0d want v=1 alu=b rd=9", bus.out_valid, bus.alu_result, bus.rd_out);
    else pass_cnt++;
    bus.out_ready = 1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd0 || bus.rd_out !== 5'd10)
      $display("FAIL bp_mulh got v=%b alu=%h rd=%0d want v=1 alu=0 rd=10", bus.out_valid, bus.alu_result, bus.rd_out);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    stim_t s; int rises;
    @(posedge clk); #1;
    s = blank(); s.d1 = 1; s.d2 = 2;
    apply(s);
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL flush_blocks_ready got=%b want=0", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_no_accept got=%b want=0", bus.out_valid);
    else pass_cnt++;
    s.op = 4'd12; s.d1 = 1000; s.d2 = 3;
    apply(s);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL flush_div got busy=%b v=%b want 0 0", bus.busy, bus.out_valid);
    else pass_cnt++;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) rises++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (rises != 0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_quiet got=%0d stray cycles rdy=%b want 0 rdy=1", rises, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    stim_t s; exp_t o; bit ok;
    logic [103:0] got;
    s = blank(); s.d1 = 32'h1234; s.d2 = 32'h1;
    run_op(s, o, ok);
    s.op = 4'd13; s.d1 = 32'hFFFF; s.d2 = 7;
    apply(s);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got = {bus.out_valid, bus.alu_result, bus.store_data, bus.branch_target,
           bus.rd_out, bus.reg_write_out, bus.branch_taken, bus.busy};
    total_cnt++;
    if (got !== '0) $display("FAIL async_reset got=%h want=0", got);
    else pass_cnt++;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL post_reset got rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_back_to_back();
    test_branches();
    test_div_latency();
    test_div_edges();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
